fifo_wr_arbiter: RTL

- Round-robin arbiter that shares the single write port of the synchronous FIFO between NREQ producers.
- Grants one requester at a time for a bounded burst of up to MAX_BURST beats.
- Drives the FIFO's we/wdata, honours the FIFO full flag, and returns a per-beat ack to the granted producer.
- Sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NREQ producers
//
// Ports:
//   clk        - clock, all state on the rising edge
//   rst        - asynchronous active-low reset
//   req        - per-requester level write request
//   data       - flattened write data, requester i on [i*N +: N]
//   ack        - one-hot pulse, the granted requester's beat was written
//   gnt        - registered one-hot grant, 0 when idle
//   gnt_id     - index of the current/last grant
//   fifo_full  - FIFO full flag
//   fifo_we    - FIFO write enable
//   fifo_wdata - FIFO write data
//   timeout    - (FIFO_WR_ARB_TIMEOUT_EN only) one-cycle pulse when a stalled grant is released
//
// Optional feature macro: FIFO_WR_ARB_TIMEOUT_EN adds a 4-bit stall counter that drops a grant
// after 15 consecutive full cycles.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int N         = 8,
    parameter int MAX_BURST = 4,
    localparam int IW       = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   gnt,
    output logic [IW-1:0]     gnt_id,
    input  logic              fifo_full,
    output logic              fifo_we,
    output logic [N-1:0]      fifo_wdata
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_gnt_id;
    logic [IW-1:0]   r_ptr;
    logic [3:0]      r_cnt;
    logic [NREQ-1:0] w_rot;
    logic [IW-1:0]   w_off;
    logic [IW:0]     w_sum;
    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_ptr_nxt;
    logic            w_burst;
    logic            w_exit;
    logic            w_to;

    // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
    assign w_rot = NREQ'({req, req} >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (w_rot[k]) w_off = IW'(k);
    end

    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_sel     = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
    assign w_ptr_nxt = (r_gnt_id == IW'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;

    assign w_burst    = (r_state == BURST);
    assign fifo_we    = w_burst & req[r_gnt_id] & ~fifo_full;
    assign fifo_wdata = w_burst ? data[r_gnt_id*N +: N] : '0;
    assign ack        = r_gnt & {NREQ{fifo_we}};
    assign gnt        = r_gnt;
    assign gnt_id     = r_gnt_id;
    assign w_exit     = w_burst & ((fifo_we & (r_cnt == 4'(MAX_BURST - 1))) | ~req[r_gnt_id] | w_to);

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    logic [3:0] r_stall;
    logic       r_timeout;

    assign w_to    = w_burst & (r_stall == 4'd15);
    assign timeout = r_timeout;

    // Counts consecutive full cycles inside a burst; any write or burst exit clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to;
            r_stall   <= (!w_burst || fifo_we || w_exit) ? 4'd0 : fifo_full ? r_stall + 4'd1 : r_stall;
        end
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
        end else if (r_state == IDLE) begin
            if (|req) begin
                r_state  <= BURST;
                r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
                r_gnt_id <= w_sel;
                r_cnt    <= '0;
            end
        end else if (w_exit) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= w_ptr_nxt;
        end else if (fifo_we) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end
endmodule
